// File: rtl/addseq_pkg.sv
// Shared types and sizing helpers for the sliced 64-bit add/subtract sequencer.
package addseq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefDataW  = 64;
  localparam int unsigned DefSliceW = 16;

  function automatic int unsigned nslice(input int unsigned data_w, input int unsigned slice_w);
    return data_w / slice_w;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational ripple-carry adder slice built from full-adder cells.
module rca_slice #(
  parameter int unsigned Width = 16
) (
  output logic [Width-1:0] s,
  output logic             cout,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin
);

  logic [Width:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < Width; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[Width];

endmodule

// File: rtl/addseq64_ctrl.sv
// Multi-cycle add/subtract sequencer: one shared slice adder per cycle, LSB slice first.
module addseq64_ctrl
  import addseq_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned SLICE_W = DefSliceW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic              cin,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] s,
  output logic              cout,
  output logic              ovf
);

  localparam int unsigned NSLICE = nslice(DATA_W, SLICE_W);
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic [DATA_W-1:0]  s_q, s_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_co;
  logic               accept;

  assign slice_a = opa_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = opb_q[idx_q*SLICE_W +: SLICE_W];

  rca_slice #(
    .Width(SLICE_W)
  ) u_slice (
    .s   (slice_s),
    .cout(slice_co),
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q)
  );

  // Requests are only heard when no operation is in flight.
  assign accept = start && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          // Subtraction is a + ~b + 1.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          s_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        s_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_co;
        if (idx_q == LastIdx) begin
          cout_d  = slice_co;
          ovf_d   = (opa_q[DATA_W-1] == opb_q[DATA_W-1]) &&
                    (slice_s[SLICE_W-1] != opa_q[DATA_W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
